cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multicycle control sequencer for the MIPS-subset CPU. It replaces the single-cycle instruction lookup with a state machine that steps each instruction through fetch, decode, execute, memory and writeback, handshakes with instruction and data memory that may insert wait states, and drives every datapath enable and select. It sits beside the datapath. It takes the fetched opcode/funct and the ALU flags, and returns the control vector, the retire count and trap status.

## Interface
- `CNT_W`, 32, width of retired-instruction counter
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `run`  in  1  level; 1 = execute, 0 = stop at next instruction boundary
- `instr_op`  in  6  opcode from instruction memory, valid with `imem_ack`
- `instr_funct`  in  6  funct from instruction memory, valid with `imem_ack`
- `imem_ack`  in  1  instruction read complete
- `dmem_ack`  in  1  data access complete
- `zero`  in  1  main ALU zero flag
- `overflow`  in  1  main ALU overflow flag
- `imem_req`  out  1  instruction read request
- `dmem_req`  out  1  data access request
- `ir_wr`  out  1  latch instruction register
- `pc_wr`  out  1  PC write enable
- `pc_sel`  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs value
- `reg_wr`  out  1  register file write enable
- `reg_dst`  out  2  00 rt, 01 rd, 10 r31
- `wb_sel`  out  2  00 ALU result, 01 memory data, 10 PC+4
- `mem_wr`  out  1  data write (qualifies `dmem_req`)
- `alu_src`  out  1  0 rt value, 1 sign-extended imm16
- `alu_ctrl`  out  3  000 ADD, 001 SUB, 010 XOR, 011 SLT
- `busy`  out  1  high in every state except IDLE and TRAP
- `trap`  out  1  sticky trap flag
- `trap_cause`  out  2  01 illegal instruction, 10 arithmetic overflow
- `instret`  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- The block registers `instr_op`/`instr_funct` internally on `imem_ack`. Decode always uses the registered copy.
- IDLE→FETCH when `run`=1.
- FETCH: `imem_req`=1 until `imem_ack`. On the ack cycle, `ir_wr`=1, `pc_wr`=1 and `pc_sel`=00, then go to DECODE.
- DECODE, per instruction:
  - J (0x02): `pc_wr`, `pc_sel`=10; retire.
  - JAL (0x03): `pc_wr`, `pc_sel`=10, `reg_wr`, `reg_dst`=10, `wb_sel`=10; retire.
  - JR (op 0, funct 0x08): `pc_wr`, `pc_sel`=11; retire.
  - Illegal op/funct → TRAP, cause 01.
  - All other legal instructions → EXEC.
- Legal set: R-type ADD 0x20, SUB 0x22, SLT 0x2a, JR 0x08; ADDI 0x08, XORI 0x0e, LW 0x23, SW 0x2b, BNE 0x05, J, JAL.
- EXEC:
  - R-type: `alu_src`=0, `alu_ctrl` from funct → WB.
  - ADDI/XORI: `alu_src`=1, ADD/XOR → WB.
  - LW/SW: `alu_src`=1, ADD → MEM.
  - BNE: SUB; if `zero`=0 then `pc_wr`, `pc_sel`=01. Retire either way.
- MEM: `dmem_req`=1 until `dmem_ack`; `mem_wr`=1 for SW. On ack, LW → WB and SW retires.
- WB: `reg_wr`=1, `reg_dst`=01 for R-type and 00 otherwise, `wb_sel`=01 for LW and 00 otherwise; retire.
- Retire:
  - `instret` +1, wrapping from all-ones to 0.
  - Next state is FETCH if `run`=1, else IDLE.
- TRAP: `trap`=1 and `trap_cause` held; all enables 0. Left only via `rst_n`.
- Any output not listed for a state is 0.

## Timing
- Reset: state IDLE. Every output is 0, including `instret` and `trap_cause`. Outputs are Moore-decoded from the state and registered instruction fields, with two exceptions: the FETCH and MEM ack-cycle strobes, and the BNE `pc_wr`, are combinational on `imem_ack`, `dmem_ack` and `zero`.
- Zero-wait memory (ack in the first cycle of the request) is legal. Minimum cycles per instruction:
  - J, JAL, JR: 2.
  - BNE: 3.
  - ALU ops and SW: 4.
  - LW: 5.
  - Each wait cycle adds 1.
- A request stays asserted and stable until its ack. An ack arriving while no request is pending is ignored.
- `run` is sampled only in IDLE and at retire. Deasserting `run` mid-instruction completes that instruction.
- `rst_n` low mid-handshake clears requests and strobes asynchronously. A stale ack after reset is ignored.
- `overflow` is sampled in EXEC only.

## Configuration
- `CPU_SEQ_OVF_TRAP_EN`:
  - Defined: ADD, SUB or ADDI with `overflow`=1 in EXEC goes to TRAP, cause 10, with no WB and no retire.
  - Undefined: `overflow` is ignored and writeback proceeds with the wrapped result. `trap_cause` 10 is never produced.

## Test plan
- Reset, then `run`=1, ADD (op 0, funct 0x20), zero-wait memory → FETCH, DECODE, EXEC, WB over 4 cycles; `reg_wr`=1 with `reg_dst`=01 in cycle 4; `instret`=1.
- LW with `dmem_ack` delayed 3 cycles → `dmem_req` high for 4 cycles with `mem_wr`=0; `reg_wr`=1 with `wb_sel`=01 in WB; 8 cycles total.
- BNE with `zero`=0, then BNE with `zero`=1 → `pc_wr`=1 and `pc_sel`=01 in the first EXEC only; `instret` increases by 2.
- JAL → exactly 2 cycles; in DECODE `pc_wr`=1, `pc_sel`=10, `reg_wr`=1, `reg_dst`=10, `wb_sel`=10.
- Opcode 0x3f → TRAP, `trap`=1, `trap_cause`=01, `busy`=0; stays there until `rst_n` pulses low.
- With `CPU_SEQ_OVF_TRAP_EN` defined, ADDI with `overflow`=1 → TRAP, cause 10, `reg_wr` never asserted. Without the macro, the same stimulus gives WB and `instret`+1.

Source files
------------

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS-subset CPU.
// Optional feature macro CPU_SEQ_OVF_TRAP_EN: trap (cause 10) on ALU overflow of ADD/SUB/ADDI.
module cpu_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       instr_op,
  input  logic [5:0]       instr_funct,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             zero,
  input  logic             overflow,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_sel,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic             mem_wr,
  output logic             alu_src,
  output logic [2:0]       alu_ctrl,
  output logic             busy,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_OVF = 2'b10;

  state_t           state_r, state_s;
  logic [5:0]       op_r, funct_r;
  logic [1:0]       cause_r, cause_s;
  logic [CNT_W-1:0] instret_r;
  logic             retire_s, latch_s;
  logic             is_rtype_s, legal_s;

  // Instruction classification from the registered opcode/funct
  always_comb begin
    is_rtype_s = (op_r == OP_RTYPE);
    legal_s    = 1'b0;
    case (op_r)
      OP_RTYPE: begin
        case (funct_r)
          FN_ADD, FN_SUB, FN_SLT, FN_JR: legal_s = 1'b1;
          default:                       legal_s = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: legal_s = 1'b1;
      default: legal_s = 1'b0;
    endcase
  end

`ifdef CPU_SEQ_OVF_TRAP_EN
  logic ovf_op_s;
  assign ovf_op_s = (op_r == OP_ADDI) ||
                    (is_rtype_s && ((funct_r == FN_ADD) || (funct_r == FN_SUB)));
`else
  logic unused_ovf_s;
  assign unused_ovf_s = overflow;
`endif

  // Next-state and control-vector decode; ack-cycle strobes and BNE pc_wr are combinational
  always_comb begin
    state_s  = state_r;
    cause_s  = cause_r;
    retire_s = 1'b0;
    latch_s  = 1'b0;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    pc_sel   = 2'b00;
    reg_wr   = 1'b0;
    reg_dst  = 2'b00;
    wb_sel   = 2'b00;
    mem_wr   = 1'b0;
    alu_src  = 1'b0;
    alu_ctrl = ALU_ADD;
    trap     = 1'b0;
    case (state_r)
      IDLE: begin
        if (run) state_s = FETCH;
        else     state_s = IDLE;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          pc_sel  = 2'b00;
          latch_s = 1'b1;
          state_s = DECODE;
        end else begin
          state_s = FETCH;
        end
      end
      DECODE: begin
        if (!legal_s) begin
          state_s = TRAP;
          cause_s = CAUSE_ILL;
        end else if (op_r == OP_J) begin
          pc_wr    = 1'b1;
          pc_sel   = 2'b10;
          retire_s = 1'b1;
        end else if (op_r == OP_JAL) begin
          pc_wr    = 1'b1;
          pc_sel   = 2'b10;
          reg_wr   = 1'b1;
          reg_dst  = 2'b10;
          wb_sel   = 2'b10;
          retire_s = 1'b1;
        end else if (is_rtype_s && (funct_r == FN_JR)) begin
          pc_wr    = 1'b1;
          pc_sel   = 2'b11;
          retire_s = 1'b1;
        end else begin
          state_s = EXEC;
        end
      end
      EXEC: begin
        if (is_rtype_s) begin
          alu_src = 1'b0;
          if (funct_r == FN_SUB)      alu_ctrl = ALU_SUB;
          else if (funct_r == FN_SLT) alu_ctrl = ALU_SLT;
          else                        alu_ctrl = ALU_ADD;
          state_s = WB;
        end else if (op_r == OP_XORI) begin
          alu_src  = 1'b1;
          alu_ctrl = ALU_XOR;
          state_s  = WB;
        end else if (op_r == OP_BNE) begin
          alu_ctrl = ALU_SUB;
          if (!zero) begin
            pc_wr  = 1'b1;
            pc_sel = 2'b01;
          end else begin
            pc_wr  = 1'b0;
          end
          retire_s = 1'b1;
        end else if ((op_r == OP_LW) || (op_r == OP_SW)) begin
          alu_src  = 1'b1;
          alu_ctrl = ALU_ADD;
          state_s  = MEM;
        end else begin
          alu_src  = 1'b1;
          alu_ctrl = ALU_ADD;
          state_s  = WB;
        end
`ifdef CPU_SEQ_OVF_TRAP_EN
        if (ovf_op_s && overflow) begin
          state_s = TRAP;
          cause_s = CAUSE_OVF;
        end else begin
          cause_s = cause_r;
        end
`endif
      end
      MEM: begin
        dmem_req = 1'b1;
        mem_wr   = (op_r == OP_SW);
        if (dmem_ack) begin
          if (op_r == OP_SW) retire_s = 1'b1;
          else               state_s  = WB;
        end else begin
          state_s = MEM;
        end
      end
      WB: begin
        reg_wr   = 1'b1;
        reg_dst  = is_rtype_s ? 2'b01 : 2'b00;
        wb_sel   = (op_r == OP_LW) ? 2'b01 : 2'b00;
        retire_s = 1'b1;
      end
      TRAP: begin
        trap    = 1'b1;
        state_s = TRAP;
      end
      default: state_s = IDLE;
    endcase
    // run is only consulted at the instruction boundary
    if (retire_s) begin
      state_s = run ? FETCH : IDLE;
    end else begin
      state_s = state_s;
    end
  end

  assign busy       = (state_r != IDLE) && (state_r != TRAP);
  assign trap_cause = cause_r;
  assign instret    = instret_r;

  // State, trap cause, retire counter and instruction-field capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cause_r   <= 2'b00;
      instret_r <= '0;
      op_r      <= 6'h00;
      funct_r   <= 6'h00;
    end else begin
      state_r <= state_s;
      cause_r <= cause_s;
      if (retire_s) instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      if (latch_s) begin
        op_r    <= instr_op;
        funct_r <= instr_funct;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed plan steps then randomized instructions vs a per-instruction model.
module tb_cpu_sequencer;

  localparam int CW = 4;
`ifdef CPU_SEQ_OVF_TRAP_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, run, imem_ack, dmem_ack, zero, overflow;
  logic [5:0]    instr_op, instr_funct;
  logic          imem_req, dmem_req, ir_wr, pc_wr, reg_wr, mem_wr, alu_src, busy, trap;
  logic [1:0]    pc_sel, reg_dst, wb_sel, trap_cause;
  logic [2:0]    alu_ctrl;
  logic [CW-1:0] instret;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int mret     = 0;

  typedef struct {
    int cyc; int pcw; int sel; int regw; int dst; int wbs;
    int dreq; int mwr; int alu; int asrc; int ret; int trap; int cause;
  } exp_t;

  logic [5:0] tab_op [11];
  logic [5:0] tab_fn [11];

  cpu_sequencer #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr_op(instr_op), .instr_funct(instr_funct),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .zero(zero), .overflow(overflow),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_wr(ir_wr), .pc_wr(pc_wr), .pc_sel(pc_sel),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .wb_sel(wb_sel), .mem_wr(mem_wr), .alu_src(alu_src),
    .alu_ctrl(alu_ctrl), .busy(busy), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected per-instruction totals, derived from the instruction class rules
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input int iw, input int dw, input logic z, input logic ov);
    exp_t e;
    int   f;
    bit   rt;
    e = '{cyc:0, pcw:1, sel:-1, regw:0, dst:-1, wbs:-1, dreq:0, mwr:0, alu:0, asrc:0,
          ret:0, trap:0, cause:0};
    f  = iw + 1;
    rt = (op == 6'h00);
    if (rt && fn == 6'h08) begin
      e.cyc = f + 1; e.pcw = 2; e.sel = 3; e.ret = 1;
    end else if (op == 6'h02 || op == 6'h03) begin
      e.cyc = f + 1; e.pcw = 2; e.sel = 2; e.ret = 1;
      if (op == 6'h03) begin e.regw = 1; e.dst = 2; e.wbs = 2; end
    end else if ((rt && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a)) || op == 6'h08 || op == 6'h0e) begin
      e.asrc = rt ? 0 : 1;
      e.alu  = (op == 6'h0e) ? 2 : (rt && fn == 6'h22) ? 1 : (rt && fn == 6'h2a) ? 3 : 0;
      if (OVF_EN && ov && (op == 6'h08 || (rt && fn != 6'h2a))) begin
        e.cyc = f + 2; e.trap = 1; e.cause = 2;
      end else begin
        e.cyc = f + 3; e.regw = 1; e.dst = rt ? 1 : 0; e.wbs = 0; e.ret = 1;
      end
    end else if (op == 6'h23 || op == 6'h2b) begin
      e.asrc = 1; e.dreq = dw + 1; e.ret = 1;
      if (op == 6'h2b) begin
        e.mwr = dw + 1; e.cyc = f + 2 + dw + 1;
      end else begin
        e.cyc = f + 2 + dw + 2; e.regw = 1; e.dst = 0; e.wbs = 1;
      end
    end else if (op == 6'h05) begin
      e.alu = 1; e.cyc = f + 2; e.ret = 1;
      if (!z) begin e.pcw = 2; e.sel = 1; end
    end else begin
      e.cyc = f + 1; e.trap = 1; e.cause = 1;
    end
    return e;
  endfunction

  task automatic idle_cycle();
    run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_imem_req", imem_req, 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    chk("reset_outputs", {imem_req, dmem_req, ir_wr, pc_wr, pc_sel, reg_wr, reg_dst, wb_sel,
                          mem_wr, alu_src, alu_ctrl, busy, trap, trap_cause, instret}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mret  = 0;
    idle_cycle();
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int iw, input int dw,
                           input logic z, input logic ov, input bit drop_run);
    exp_t e;
    int n_ir = 0, n_ireq = 0, n_dreq = 0, n_mwr = 0, n_pcw = 0, n_regw = 0, n_busy = 0;
    int sel = -1, fsel = -1, dst = -1, wbs = -1, alu = 0, asrc = 0;
    e   = model(op, fn, iw, dw, z, ov);
    run = 1'b1;
    for (int c = 0; c < e.cyc; c++) begin
      imem_ack    = (n_ireq == iw);
      dmem_ack    = (n_dreq == dw);
      instr_op    = imem_ack ? op : 6'($urandom);
      instr_funct = imem_ack ? fn : 6'($urandom);
      zero        = (c == iw + 2) ? z  : 1'($urandom);
      overflow    = (c == iw + 2) ? ov : 1'($urandom);
      if (drop_run && c == 1) run = 1'b0;
      #1;
      if (imem_req) n_ireq++;
      if (dmem_req) n_dreq++;
      if (mem_wr)   n_mwr++;
      if (busy)     n_busy++;
      if (ir_wr) begin n_ir++; fsel = pc_wr ? int'(pc_sel) : 7; end
      if (pc_wr) begin n_pcw++; if (!ir_wr) sel = int'(pc_sel); end
      if (reg_wr) begin n_regw++; dst = int'(reg_dst); wbs = int'(wb_sel); end
      alu  = alu | int'(alu_ctrl);
      asrc = asrc | int'(alu_src);
      @(negedge clk);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    mret = (mret + e.ret) % (1 << CW);
    chk("ir_wr_count", n_ir, 1);
    chk("imem_req_cycles", n_ireq, iw + 1);
    chk("fetch_pc_sel", fsel, 0);
    chk("dmem_req_cycles", n_dreq, e.dreq);
    chk("mem_wr_cycles", n_mwr, e.mwr);
    chk("pc_wr_count", n_pcw, e.pcw);
    chk("pc_sel", sel, e.sel);
    chk("reg_wr_count", n_regw, e.regw);
    chk("reg_dst", dst, e.dst);
    chk("wb_sel", wbs, e.wbs);
    chk("alu_ctrl", alu, e.alu);
    chk("alu_src", asrc, e.asrc);
    chk("busy_cycles", n_busy, e.cyc);
    chk("instret", instret, mret);
    chk("trap", trap, e.trap);
    if (e.trap != 0) begin
      for (int k = 0; k < 2; k++) begin
        run = 1'b1; imem_ack = 1'b1;
        #1;
        chk("trap_held", trap, 1);
        chk("trap_cause", trap_cause, e.cause);
        chk("trap_busy", busy, 0);
        chk("trap_quiet", {imem_req, pc_wr, reg_wr, dmem_req}, 0);
        @(negedge clk);
      end
      do_reset();
    end else if (drop_run) begin
      chk("stopped_busy", busy, 0);
      idle_cycle();
    end
  endtask

  initial begin
    tab_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0e, 6'h23, 6'h2b, 6'h05, 6'h02, 6'h03};
    tab_fn = '{6'h20, 6'h22, 6'h2a, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    rst_n = 1'b0; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    zero = 1'b0; overflow = 1'b0; instr_op = 6'h00; instr_funct = 6'h00;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Directed plan steps
    run_instr(6'h00, 6'h20, 0, 0, 1'b0, 1'b0, 1'b0);   // ADD, zero-wait
    run_instr(6'h23, 6'h00, 0, 3, 1'b0, 1'b0, 1'b0);   // LW, 3 data wait states
    run_instr(6'h05, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);   // BNE taken
    run_instr(6'h05, 6'h00, 0, 0, 1'b1, 1'b0, 1'b0);   // BNE not taken
    run_instr(6'h03, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);   // JAL
    run_instr(6'h2b, 6'h00, 2, 1, 1'b0, 1'b0, 1'b0);   // SW with waits
    run_instr(6'h0e, 6'h00, 1, 0, 1'b0, 1'b1, 1'b0);   // XORI ignores overflow
    run_instr(6'h00, 6'h2a, 0, 0, 1'b0, 1'b1, 1'b0);   // SLT ignores overflow
    run_instr(6'h02, 6'h00, 0, 0, 1'b0, 1'b0, 1'b1);   // J, run dropped mid-instruction
    run_instr(6'h00, 6'h08, 0, 0, 1'b0, 1'b0, 1'b0);   // JR
    run_instr(6'h08, 6'h00, 0, 0, 1'b0, 1'b1, 1'b0);   // ADDI with overflow
    run_instr(6'h3f, 6'h00, 0, 0, 1'b0, 1'b0, 1'b0);   // illegal opcode

    // Reset in the middle of an instruction fetch, then a stale ack
    run_instr(6'h00, 6'h22, 0, 0, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b0;
    #1;
    chk("fetch_pending", imem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("async_clear_req", imem_req, 0);
    chk("async_clear_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1; run = 1'b0; imem_ack = 1'b1; instr_op = 6'h3f;
    #1;
    chk("stale_ack_ir_wr", ir_wr, 0);
    @(negedge clk);
    #1;
    chk("stale_ack_idle", {busy, trap, imem_req}, 0);
    mret = 0;
    idle_cycle();

    // Randomized instruction stream
    for (int i = 0; i < 150; i++) begin
      int         k;
      logic [5:0] op, fn;
      k = $urandom_range(0, 12);
      if (k < 11) begin
        op = tab_op[k];
        fn = (op == 6'h00) ? tab_fn[k] : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
